// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART (start, DATA_BITS LSB first, optional parity, stop bits).
// Define UART_BREAK_DETECT_EN to generate the rx_break pulse; otherwise rx_break is tied low.
module uart_core #(
  parameter int DIVIDER   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] txdata,
  input  logic                 txstrobe,
  output logic                 txready,
  output logic [DATA_BITS-1:0] rxdata,
  output logic                 rxstrobe,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break
);
  localparam int CW = $clog2(DIVIDER);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(DIVIDER / 2);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d;
  logic tx_q, tx_d;

  assign tx      = tx_q;
  assign txready = (tx_state_q == TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // tx is registered: each branch loads the level of the bit that starts next cycle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (txstrobe) begin
          tx_state_d = TX_START;
          tx_sh_d    = txdata;
          tx_par_d   = (^txdata) ^ ODD;
          tx_d       = 1'b0;
        end
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
        tx_d       = tx_sh_q[0];
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh_q >> 1;
        if (tx_bit_q == DATA_LAST) begin
          tx_bit_d   = '0;
          tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
          tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          tx_d     = tx_sh_q[1];
        end
      end
      TX_PARITY: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_STOP;
        tx_d       = 1'b1;
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
        else tx_bit_d = tx_bit_q + 4'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  rx_state_e rx_state_q, rx_state_d;
  logic rx_meta_q, rx_sync_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic rx_pe_q, rx_pe_d;
  logic [DATA_BITS-1:0] rxdata_q, rxdata_d;
  logic rxstrobe_q, rxstrobe_d;
  logic perr_q, perr_d;
  logic ferr_q, ferr_d;
`ifdef UART_BREAK_DETECT_EN
  logic rx_zero_q, rx_zero_d;
  logic brk_q, brk_d;
  assign rx_break = brk_q;
`else
  assign rx_break = 1'b0;
`endif

  assign rxdata        = rxdata_q;
  assign rxstrobe      = rxstrobe_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pe_q    <= 1'b0;
      rxdata_q   <= '0;
      rxstrobe_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      rx_zero_q  <= 1'b0;
      brk_q      <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pe_q    <= rx_pe_d;
      rxdata_q   <= rxdata_d;
      rxstrobe_q <= rxstrobe_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef UART_BREAK_DETECT_EN
      rx_zero_q  <= rx_zero_d;
      brk_q      <= brk_d;
`endif
    end
  end

  // rx_cnt_q holds the clock index within the start bit, then clocks since the last sample.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_pe_d    = rx_pe_q;
    rxdata_d   = rxdata_q;
    rxstrobe_d = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
`ifdef UART_BREAK_DETECT_EN
    rx_zero_d  = rx_zero_q;
    brk_d      = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CW'(1);
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == BIT_HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_pe_d    = 1'b0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
`ifdef UART_BREAK_DETECT_EN
        rx_zero_d  = 1'b1;
`endif
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
`ifdef UART_BREAK_DETECT_EN
        rx_zero_d = rx_zero_q & ~rx_sync_q;
`endif
        if (rx_bit_q == DATA_LAST) rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
        else rx_bit_d = rx_bit_q + 4'd1;
      end
      RX_PARITY: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_pe_d    = rx_sync_q ^ (^rx_sh_q) ^ ODD;
        rx_state_d = RX_STOP;
`ifdef UART_BREAK_DETECT_EN
        rx_zero_d  = rx_zero_q & ~rx_sync_q;
`endif
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rxdata_d   = rx_sh_q;
        rxstrobe_d = 1'b1;
        perr_d     = rx_pe_q;
        ferr_d     = ~rx_sync_q;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_IDLE;
`ifdef UART_BREAK_DETECT_EN
        brk_d      = rx_zero_q & ~rx_sync_q;
`endif
      end
      RX_WAIT_IDLE: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end
endmodule
